// File: rtl/regfile.sv
// 32 x 32-bit register file with two bypassed read ports, a raw debug read port
// and a committed-write counter. Register 0 is hard-wired to zero.
module regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  wAddr,
   input  logic [31:0] wData,
   input  logic        re1,
   input  logic [4:0]  rAddr1,
   output logic [31:0] rData1,
   input  logic        re2,
   input  logic [4:0]  rAddr2,
   output logic [31:0] rData2,
   input  logic [4:0]  dbgAddr,
   output logic [31:0] dbgData,
   output logic [31:0] wrCount
);

   logic [31:0] r_mem [0:31];
   logic [31:0] r_wr_count;
   logic        w_commit;

   assign w_commit = we && (wAddr != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_mem[i] <= 32'h0;
         end
         r_wr_count <= 32'h0;
      end else if (w_commit) begin
         r_mem[wAddr] <= wData;
         r_wr_count   <= r_wr_count + 32'd1;
      end
   end

   // Read priority: reset, disable, index 0, same-cycle write-through, storage.
   always_comb begin
      rData1 = 32'h0;
      if (rst || !re1 || (rAddr1 == 5'd0)) begin
         rData1 = 32'h0;
      end else if (we && (wAddr == rAddr1)) begin
         rData1 = wData;
      end else begin
         rData1 = r_mem[rAddr1];
      end
   end

   always_comb begin
      rData2 = 32'h0;
      if (rst || !re2 || (rAddr2 == 5'd0)) begin
         rData2 = 32'h0;
      end else if (we && (wAddr == rAddr2)) begin
         rData2 = wData;
      end else begin
         rData2 = r_mem[rAddr2];
      end
   end

   // Debug port shows stored contents only; an in-flight write is not visible.
   always_comb begin
      dbgData = 32'h0;
      if (!rst && (dbgAddr != 5'd0)) begin
         dbgData = r_mem[dbgAddr];
      end
   end

   assign wrCount = rst ? 32'h0 : r_wr_count;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: drives on the falling edge, checks between edges.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  wAddr;
   logic [31:0] wData;
   logic        re1;
   logic [4:0]  rAddr1;
   logic [31:0] rData1;
   logic        re2;
   logic [4:0]  rAddr2;
   logic [31:0] rData2;
   logic [4:0]  dbgAddr;
   logic [31:0] dbgData;
   logic [31:0] wrCount;

   int checks = 0;
   int errors = 0;

   regfile dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wAddr   (wAddr),
      .wData   (wData),
      .re1     (re1),
      .rAddr1  (rAddr1),
      .rData1  (rData1),
      .re2     (re2),
      .rAddr2  (rAddr2),
      .rData2  (rData2),
      .dbgAddr (dbgAddr),
      .dbgData (dbgData),
      .wrCount (wrCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge (one rising edge in between), then settle.
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; we = 1'b1; wAddr = 5'd4; wData = 32'hCAFEF00D;
      re1 = 1'b1; rAddr1 = 5'd5; re2 = 1'b1; rAddr2 = 5'd31; dbgAddr = 5'd4;
      #2;
      check("rst_rdata1", rData1, 32'h0);
      check("rst_rdata2", rData2, 32'h0);
      check("rst_dbg", dbgData, 32'h0);
      check("rst_wrcount", wrCount, 32'h0);
      next_cycle();
      check("rst_write_ignored", dbgData, 32'h0);

      rst = 1'b0; we = 1'b0;
      #1;
      check("post_rst_rdata1", rData1, 32'h0);
      check("post_rst_rdata2", rData2, 32'h0);
      check("post_rst_wrcount", wrCount, 32'h0);

      // Write 7, then read it back through storage.
      we = 1'b1; wAddr = 5'd7; wData = 32'hDEADBEEF;
      next_cycle();
      we = 1'b0; rAddr1 = 5'd7; dbgAddr = 5'd7;
      #1;
      check("wr7_rdata1", rData1, 32'hDEADBEEF);
      check("wr7_dbg", dbgData, 32'hDEADBEEF);
      check("wr7_wrcount", wrCount, 32'd1);

      // Same-cycle bypass on both ports; debug shows the old stored value.
      we = 1'b1; wAddr = 5'd3; wData = 32'h12345678;
      rAddr1 = 5'd3; rAddr2 = 5'd3; dbgAddr = 5'd3;
      #1;
      check("byp3_rdata1", rData1, 32'h12345678);
      check("byp3_rdata2", rData2, 32'h12345678);
      check("byp3_dbg_old", dbgData, 32'h0);
      next_cycle();
      we = 1'b0;
      #1;
      check("wr3_dbg", dbgData, 32'h12345678);
      check("wr3_wrcount", wrCount, 32'd2);

      // Write to register 0 is discarded.
      we = 1'b1; wAddr = 5'd0; wData = 32'hFFFFFFFF; rAddr1 = 5'd0; dbgAddr = 5'd0;
      #1;
      check("r0_same_rdata1", rData1, 32'h0);
      next_cycle();
      we = 1'b0;
      #1;
      check("r0_next_rdata1", rData1, 32'h0);
      check("r0_dbg", dbgData, 32'h0);
      check("r0_wrcount", wrCount, 32'd2);

      // Read enable gating.
      we = 1'b1; wAddr = 5'd9; wData = 32'hA5A5A5A5;
      next_cycle();
      we = 1'b0; re1 = 1'b0; rAddr1 = 5'd9;
      #1;
      check("re1_off", rData1, 32'h0);
      re1 = 1'b1;
      #1;
      check("re1_on", rData1, 32'hA5A5A5A5);
      check("wr9_wrcount", wrCount, 32'd3);

      // Disabled port must not bypass; enabled port does.
      we = 1'b1; wAddr = 5'd12; wData = 32'h00000011;
      re1 = 1'b1; rAddr1 = 5'd12; re2 = 1'b0; rAddr2 = 5'd12;
      #1;
      check("byp_re2_off", rData2, 32'h0);
      check("byp_re1_on", rData1, 32'h00000011);
      next_cycle();
      re2 = 1'b1;

      // Overwrite 7: bypass shows new data, storage old until the edge.
      we = 1'b1; wAddr = 5'd7; wData = 32'h0BADF00D; rAddr1 = 5'd7; rAddr2 = 5'd9; dbgAddr = 5'd7;
      #1;
      check("ovw_byp", rData1, 32'h0BADF00D);
      check("ovw_other_port", rData2, 32'hA5A5A5A5);
      check("ovw_dbg_old", dbgData, 32'hDEADBEEF);
      next_cycle();
      we = 1'b0;
      #1;
      check("ovw_dbg_new", dbgData, 32'h0BADF00D);
      check("ovw_wrcount", wrCount, 32'd5);

      // Asynchronous reset between edges with a write pending.
      we = 1'b1; wAddr = 5'd20; wData = 32'h00000055; dbgAddr = 5'd7;
      #1;
      rst = 1'b1;
      #1;
      check("arst_rdata1", rData1, 32'h0);
      check("arst_rdata2", rData2, 32'h0);
      check("arst_dbg", dbgData, 32'h0);
      check("arst_wrcount", wrCount, 32'h0);
      next_cycle();
      rst = 1'b0; we = 1'b0;
      #1;
      check("arst_reg7_cleared", dbgData, 32'h0);
      rAddr2 = 5'd9;
      dbgAddr = 5'd20;
      #1;
      check("arst_write_lost", dbgData, 32'h0);
      check("arst_reg9_cleared", rData2, 32'h0);
      check("arst_wrcount_after", wrCount, 32'h0);

      // First write after reset is accepted.
      we = 1'b1; wAddr = 5'd20; wData = 32'h00000077;
      next_cycle();
      we = 1'b0;
      #1;
      check("first_wr_dbg", dbgData, 32'h00000077);
      check("first_wr_wrcount", wrCount, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
